// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch and
// data access. Data has fixed priority; a starvation counter bounds fetch wait.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_dqm,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [1:0]        m_dqm,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {IDLE, RD_I, RD_D} state_t;

  state_t     state;
  logic [3:0] starveCnt;
  logic       starved;

  assign starved = (starveCnt == 4'(STARVE_MAX));
  assign d_gnt   = d_req && !(i_req && starved);
  assign i_gnt   = i_req && !d_gnt;

  assign m_en    = i_gnt | d_gnt;
  assign m_we    = d_gnt & d_we;
  assign m_addr  = d_gnt ? d_addr : (i_gnt ? i_addr : '0);
  assign m_wdata = d_gnt ? d_wdata : '0;
  assign m_dqm   = d_gnt ? d_dqm : 2'b00;

  // Read data is shared and unqualified; the owner is told by rvalid.
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign i_rvalid = (state == RD_I);
  assign d_rvalid = (state == RD_D);

  // State records which port owns the read returning next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (i_gnt) begin
      state <= RD_I;
    end else if (d_gnt && !d_we) begin
      state <= RD_D;
    end else begin
      state <= IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt <= 4'd0;
    end else if (i_gnt || !i_req) begin
      starveCnt <= 4'd0;
    end else if (d_gnt && !starved) begin
      starveCnt <= starveCnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= 16'd0;
    end else if (i_req && d_req) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a cycle-level
// model of the grant rules, a reference memory and read-return expectations.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32, DATA_W = 32, SMAX = 3;

  logic clk = 1'b0, rst;
  logic i_req, i_gnt, i_rvalid, d_req, d_we, d_gnt, d_rvalid, m_en, m_we;
  logic [ADDR_W-1:0] i_addr, d_addr, m_addr;
  logic [DATA_W-1:0] i_rdata, d_wdata, d_rdata, m_wdata, m_rdata;
  logic [1:0]  d_dqm, m_dqm;
  logic [15:0] conflict_cnt;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_dqm(d_dqm),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_dqm(m_dqm),
    .m_rdata(m_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Memory fixture: synchronous, one-cycle read latency, preloaded mem[a] = a + 0x100.
  logic [DATA_W-1:0] mem [256];
  logic loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'(k + 'h100);
      loaded  <= 1'b1;
      m_rdata <= '0;
    end else if (m_en) begin
      if (m_we) mem[m_addr[7:0]] <= m_wdata;
      else      m_rdata <= mem[m_addr[7:0]];
    end
  end

  // Reference model state.
  int          checks = 0, errors = 0;
  logic [31:0] refMem [256];
  int          fetchWait, conflictCount;
  bit          expIV, expDV;
  logic [31:0] expRd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    expIV = 0; expDV = 0; fetchWait = 0; conflictCount = 0;
  endtask

  // One bus cycle: drive, check combinational and returning-read outputs, advance.
  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [1:0] dq);
    bit eD, eI;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; d_dqm = dq;
    #1;
    eD = dr && !(ir && fetchWait == SMAX);
    eI = ir && !eD;
    chk("i_gnt", i_gnt, eI);
    chk("d_gnt", d_gnt, eD);
    chk("m_en", m_en, eI | eD);
    chk("m_we", m_we, eD && dw);
    chk("m_addr", m_addr, eD ? da : (eI ? ia : 32'h0));
    chk("m_wdata", m_wdata, eD ? dwd : 32'h0);
    chk("m_dqm", m_dqm, eD ? dq : 2'b00);
    chk("i_rvalid", i_rvalid, expIV);
    chk("d_rvalid", d_rvalid, expDV);
    if (expIV) chk("i_rdata", i_rdata, expRd);
    if (expDV) chk("d_rdata", d_rdata, expRd);
    chk("conflict_cnt", conflict_cnt, conflictCount);
    @(posedge clk);
    expIV = eI;
    expDV = eD && !dw;
    if (eI) expRd = refMem[ia[7:0]];
    else if (eD && !dw) expRd = refMem[da[7:0]];
    if (eD && dw) refMem[da[7:0]] = dwd;
    if (!ir || eI) fetchWait = 0;
    else if (fetchWait < SMAX) fetchWait++;
    conflictCount = (conflictCount + ((ir && dr) ? 1 : 0)) % 65536;
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 2'b00);
  endtask

  // Synchronous-looking reset window, applied between edges.
  task automatic pulseReset();
    i_req = 0; d_req = 0; d_we = 0;
    rst = 1'b1; #2; rst = 1'b0;
    modelReset();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) refMem[k] = 32'(k + 'h100);
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_dqm = 0;
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_conflict", conflict_cnt, 0);
    chk("rst_m_en", m_en, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fetch only.
    for (int a = 'h10; a <= 'h12; a++) step(1, 32'(a), 0, 0, 0, 0, 2'b00);
    #1;
    chk("fetch_last_rvalid", i_rvalid, 1);
    chk("fetch_last_rdata", i_rdata, 32'h112);
    idle();

    // Data priority with starvation relief, counted from a clean reset.
    pulseReset();
    for (int c = 1; c <= 5; c++) step(1, 32'h30, 1, 0, 32'h20, 0, 2'b11);
    #1;
    chk("prio_conflict5", conflict_cnt, 16'd5);
    idle();

    // Write then read same address.
    step(0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 2'b11);
    step(0, 0, 1, 0, 32'h40, 0, 2'b11);
    #1;
    chk("wr_rd_rvalid", d_rvalid, 1);
    chk("wr_rd_rdata", d_rdata, 32'hDEADBEEF);
    idle();

    // Interleaved ownership.
    step(0, 0, 1, 0, 32'h50, 0, 2'b01);
    step(1, 32'h60, 0, 0, 0, 0, 2'b00);
    idle();
    idle();

    // Reset mid-read.
    step(1, 32'h70, 0, 0, 0, 0, 2'b00);
    i_req = 0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_i_rvalid", i_rvalid, 0);
    chk("midrst_conflict", conflict_cnt, 0);
    #1 rst = 1'b0;
    modelReset();
    @(posedge clk); #1;
    idle();
    step(1, 32'h10, 1, 0, 32'h11, 0, 2'b00);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 2000; n++)
      step($urandom_range(0, 1), 32'($urandom_range(0, 255)), $urandom_range(0, 1),
           $urandom_range(0, 1), 32'($urandom_range(0, 255)), $urandom, 2'($urandom_range(0, 3)));
    idle();

    // Counter wrap: exactly 65536 conflict cycles from reset.
    pulseReset();
    for (int n = 0; n < 65536; n++)
      step(1, 32'($urandom_range(0, 255)), 1, 0, 32'($urandom_range(0, 255)), 0, 2'b11);
    #1;
    chk("wrap_zero", conflict_cnt, 16'd0);
    idle();
    step(1, 32'h5, 1, 0, 32'h6, 0, 2'b00);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-ported synchronous memory between the instruction-fetch requester and the data-access (MEM stage) requester. This lets a unified program/data memory replace the separate instruction and data memories. Data accesses have fixed priority, and a starvation counter guarantees that fetch makes forward progress. The grant outputs feed the hazard logic, which drives stall_IF and stall_ID.

## Interface
Parameters:
- ADDR_W, 32, address width of both requesters and the memory
- DATA_W, 32, data width
- STARVE_MAX, 3, number of consecutive denied fetch cycles after which fetch wins over data (range 1..15)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- i_req  in  1  fetch read request
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted this cycle (combinational)
- i_rvalid  out  1  i_rdata valid (registered)
- i_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_dqm  in  2  byte/half/word mask, passed unchanged to memory
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  d_rdata valid (registered; reads only)
- d_rdata  out  DATA_W  data read data
- m_en  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_dqm  out  2  memory mask
- m_rdata  in  DATA_W  memory read data, valid one cycle after m_en && !m_we
- conflict_cnt  out  16  count of cycles in which both i_req and d_req were high

## Operation
- Grant rule, evaluated each cycle:
  - starved = (starve_cnt == STARVE_MAX).
  - d_gnt = d_req && !(i_req && starved).
  - i_gnt = i_req && !d_gnt.
  - At most one grant is asserted per cycle.
- Memory command is driven combinationally from the granted requester:
  - m_en = i_gnt | d_gnt.
  - m_we = d_gnt & d_we.
  - m_addr comes from the winner.
  - m_wdata = d_wdata and m_dqm = d_dqm when d_gnt; both are 0 otherwise.
  - When idle: m_addr = 0, m_we = 0.
- Requester rule: hold req and all request fields stable until gnt is seen. A dropped request is permitted and simply is not serviced.
- starve_cnt (4 bits):
  - Cleared when i_gnt or !i_req.
  - Otherwise increments when i_req && d_gnt, saturating at STARVE_MAX.
- Response tracking FSM, state is the owner of the read in flight:
  - IDLE -> RD_I on i_gnt.
  - IDLE -> RD_D on d_gnt && !d_we.
  - A data write leaves the FSM in IDLE or moves it to IDLE; writes complete at grant and produce no rvalid.
  - From RD_I or RD_D, the next state is chosen by the same rules from the current cycle's grant. Back-to-back accesses are allowed: one access per cycle, fully pipelined.
- i_rvalid = (state == RD_I) and d_rvalid = (state == RD_D).
- i_rdata = d_rdata = m_rdata, unqualified. Consumers must gate with rvalid.
- conflict_cnt: increments when i_req && d_req; wraps from 0xFFFF to 0.

## Timing
- Grant latency: 0 cycles (same cycle as req when the port wins).
- Read latency: rvalid is high exactly 1 cycle after the granting edge.
- Throughput: 1 access per cycle.
- Worst-case fetch wait under continuous data traffic: STARVE_MAX cycles. Fetch is granted in cycle STARVE_MAX+1 of its request.
- Reset values: state = IDLE, starve_cnt = 0, conflict_cnt = 0, i_rvalid = 0, d_rvalid = 0.
- All combinational outputs follow their inputs; with no requests they are all 0.
- Reset mid-read: the in-flight rvalid is dropped and never asserted after reset deasserts.
- Simultaneous requests when not starved: data wins, and fetch is denied for that cycle.
- Simultaneous requests when starved: fetch wins, data is denied for that cycle, and starve_cnt clears at the next edge.
- A data write that was granted on the starved cycle's predecessor completes normally; no ordering guarantee is given between the two ports.

## Test plan
- Fetch only: i_req=1, i_addr=0x10, 0x11, 0x12 on consecutive cycles, memory preloaded with mem[a]=a+0x100.
  - Required: i_gnt=1 every cycle.
  - Required: i_rvalid=1 with i_rdata=0x110, 0x111, 0x112 one cycle later each.
  - Required: d_rvalid=0 throughout.
- Data priority: i_req and d_req high together, data read at 0x20, STARVE_MAX=3.
  - Required: d_gnt=1 and i_gnt=0 in cycles 1-3.
  - Required: i_gnt=1 and d_gnt=0 in cycle 4, then d_gnt=1 in cycle 5.
  - Required: conflict_cnt=5 after 5 cycles.
- Write then read same address: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_dqm=2'b11, then d_we=0 at 0x40.
  - Required: no d_rvalid for the write.
  - Required: d_rvalid=1 with d_rdata=0xDEADBEEF the cycle after the read grant.
- Interleaved ownership: d read in cycle 1, i read in cycle 2.
  - Required: d_rvalid in cycle 2 only, i_rvalid in cycle 3 only.
  - Required: m_addr switches each cycle.
- Reset mid-read: i_gnt in cycle 1, rst pulsed asynchronously between edges before cycle 2.
  - Required: i_rvalid=0 immediately and stays 0.
  - Required: starve_cnt=0 and conflict_cnt=0.
- Counter wrap: force 65536 conflict cycles.
  - Required: conflict_cnt returns to 0.
  - Required: grant pattern is unaffected.
